// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port sram arbiter.
// States, port ids and the access-counter width helper live here.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Counter holds ACCESS_CYCLES-1 down to 0; never narrower than one bit.
  function automatic int cnt_w(input int access_cycles);
    return (access_cycles > 1) ? $clog2(access_cycles) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and sram-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the fetch/mem/sram side.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              sram_cs;
  logic              sram_oe;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_dout,
    output i_rdata, i_ack, d_rdata, d_ack,
           sram_cs, sram_oe, sram_we, sram_addr, sram_din, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_dout,
    input  i_rdata, i_ack, d_rdata, d_ack,
           sram_cs, sram_oe, sram_we, sram_addr, sram_din, busy
  );
endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-request round-robin arbiter: combinational grant, registered last grant.
// On contention the port that did not win last time is chosen.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_port,
  output logic       gnt_vld,
  output logic       gnt_port
);

  logic last_grant;

  // Reset to the data port so the instruction port wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_grant <= PORT_D;
    else if (upd) last_grant <= upd_port;
  end

  always_comb begin
    gnt_vld = |req;
    if (&req) gnt_port = ~last_grant;
    else      gnt_port = req[PORT_D] ? PORT_D : PORT_I;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous sram between instruction-fetch and data ports.
// IDLE -> ACCESS (ACCESS_CYCLES with cs high) -> RESP (one-cycle ack).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input logic                clk,
  input logic                rst_n,
  sram_port_arbiter_if.slave bus
);

  localparam int             CW       = cnt_w(ACCESS_CYCLES);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  if (ACCESS_CYCLES < 1) begin : g_bad_cycles
    $error("sram_port_arbiter: ACCESS_CYCLES must be >= 1");
  end

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              owner_q;
  req_t              cur_q, sel;
  logic              cs_q, oe_q, we_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              gnt_vld, gnt_port;
  logic              take, capture, done;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({bus.d_req, bus.i_req}),
    .upd      (done),
    .upd_port (owner_q),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  // Payload of the winning port; fetch is always a read and reads drive din=0.
  always_comb begin
    sel = '0;
    if (gnt_port == PORT_D) begin
      sel.we    = bus.d_we;
      sel.addr  = bus.d_addr;
      sel.wdata = bus.d_we ? bus.d_wdata : '0;
    end else begin
      sel.addr  = bus.i_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (gnt_vld) begin
        take    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: if (cnt_q == '0) begin
        capture = ~cur_q.we;
        state_d = RESP;
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // sram strobes stay constant across ACCESS and drop on entry to RESP;
  // address and write data are left holding for the sram's benefit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      owner_q   <= PORT_I;
      cur_q     <= '0;
      cs_q      <= 1'b0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (take) begin
        owner_q <= gnt_port;
        cur_q   <= sel;
        cnt_q   <= CNT_LOAD;
        cs_q    <= 1'b1;
        oe_q    <= ~sel.we;
        we_q    <= sel.we;
      end else if (state_q == ACCESS) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          cs_q <= 1'b0;
          oe_q <= 1'b0;
          we_q <= 1'b0;
        end
      end
      if (capture) begin
        if (owner_q == PORT_D) d_rdata_q <= bus.sram_dout;
        else                   i_rdata_q <= bus.sram_dout;
      end
    end
  end

  assign bus.sram_cs   = cs_q;
  assign bus.sram_oe   = oe_q;
  assign bus.sram_we   = we_q;
  assign bus.sram_addr = cur_q.addr;
  assign bus.sram_din  = cur_q.wdata;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ack     = (state_q == RESP) && (owner_q == PORT_I);
  assign bus.d_ack     = (state_q == RESP) && (owner_q == PORT_D);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: an ACCESS_CYCLES=2 instance and an ACCESS_CYCLES=1 instance,
// each with a small asynchronous sram model.
module tb_sram_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  sram_port_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(32), .DATA_W(32)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (b2)
  );
  sram_port_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sparse sram: 0x00400000 -> 4, 0x10000000 -> 8.
  function automatic logic [3:0] midx(input logic [31:0] a);
    return {a[28], a[22], a[3:2]};
  endfunction

  logic [31:0] mem2 [16] = '{4: 32'h8C010004, default: 32'h0};
  logic [31:0] mem1 [16] = '{4: 32'h8C010004, default: 32'h0};

  assign b2.sram_dout = (b2.sram_cs && b2.sram_oe) ? mem2[midx(b2.sram_addr)] : 32'hBAD0BAD0;
  assign b1.sram_dout = (b1.sram_cs && b1.sram_oe) ? mem1[midx(b1.sram_addr)] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (b2.sram_cs && b2.sram_we) mem2[midx(b2.sram_addr)] <= b2.sram_din;
    if (b1.sram_cs && b1.sram_we) mem1[midx(b1.sram_addr)] <= b1.sram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next cycle: inputs drive and outputs sample here.
  task automatic nxt();
    @(posedge clk);
    #4;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    b2.i_req = 0; b2.i_addr = '0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = '0; b2.d_wdata = '0;
    b1.i_req = 0; b1.i_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    nxt(); nxt();

    // Reset state
    chk1("rst_cs", b2.sram_cs, 1'b0);
    chk1("rst_busy", b2.busy, 1'b0);
    chk1("rst_acks", b2.i_ack | b2.d_ack, 1'b0);
    chk("rst_addr", b2.sram_addr, 32'h0);
    chk("rst_i_rdata", b2.i_rdata, 32'h0);
    chk("rst_d_rdata", b2.d_rdata, 32'h0);
    rst_n = 1'b1;
    nxt();

    // Instruction read: cycle 0 request, cs in 1-2, ack in 3
    b2.i_req = 1; b2.i_addr = 32'h0040_0000;
    chk1("ir_c0_cs", b2.sram_cs, 1'b0);
    nxt();
    chk1("ir_c1_cs", b2.sram_cs, 1'b1);
    chk1("ir_c1_oe", b2.sram_oe, 1'b1);
    chk1("ir_c1_we", b2.sram_we, 1'b0);
    chk("ir_c1_addr", b2.sram_addr, 32'h0040_0000);
    chk1("ir_c1_ack", b2.i_ack, 1'b0);
    nxt();
    chk1("ir_c2_cs", b2.sram_cs, 1'b1);
    chk1("ir_c2_ack", b2.i_ack, 1'b0);
    nxt();
    chk1("ir_c3_ack", b2.i_ack, 1'b1);
    chk1("ir_c3_dack", b2.d_ack, 1'b0);
    chk1("ir_c3_cs", b2.sram_cs, 1'b0);
    chk("ir_c3_rdata", b2.i_rdata, 32'h8C01_0004);
    chk("ir_c3_addr_hold", b2.sram_addr, 32'h0040_0000);
    b2.i_req = 0;
    nxt();
    chk1("ir_c4_ack", b2.i_ack, 1'b0);
    chk1("ir_c4_busy", b2.busy, 1'b0);

    // Data write: oe low, we high, d_rdata untouched
    b2.d_req = 1; b2.d_we = 1; b2.d_addr = 32'h1000_0000; b2.d_wdata = 32'hDEAD_BEEF;
    nxt();
    chk1("wr_c1_we", b2.sram_we, 1'b1);
    chk1("wr_c1_oe", b2.sram_oe, 1'b0);
    chk("wr_c1_din", b2.sram_din, 32'hDEAD_BEEF);
    nxt();
    chk1("wr_c2_cs", b2.sram_cs, 1'b1);
    nxt();
    chk1("wr_c3_dack", b2.d_ack, 1'b1);
    chk("wr_c3_d_rdata", b2.d_rdata, 32'h0);
    b2.d_req = 0;
    nxt();

    // Data read of the same address
    b2.d_req = 1; b2.d_we = 0; b2.d_wdata = 32'h5555_5555;
    nxt();
    chk1("rd_c1_oe", b2.sram_oe, 1'b1);
    chk("rd_c1_din", b2.sram_din, 32'h0);
    nxt(); nxt();
    chk1("rd_c3_dack", b2.d_ack, 1'b1);
    chk("rd_c3_d_rdata", b2.d_rdata, 32'hDEAD_BEEF);
    chk("rd_c3_i_rdata", b2.i_rdata, 32'h8C01_0004);
    b2.d_req = 0;
    nxt();

    // Early drop: one-cycle d_req, payload scrambled afterwards
    b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h0040_0000;
    nxt();
    b2.d_req = 0; b2.d_addr = 32'h1000_0000; b2.d_we = 1;
    chk1("ed_c1_cs", b2.sram_cs, 1'b1);
    chk("ed_c1_addr", b2.sram_addr, 32'h0040_0000);
    nxt(); nxt();
    chk1("ed_c3_dack", b2.d_ack, 1'b1);
    chk("ed_c3_d_rdata", b2.d_rdata, 32'h8C01_0004);
    nxt();
    chk1("ed_c4_busy", b2.busy, 1'b0);
    nxt();
    chk1("ed_c5_cs", b2.sram_cs, 1'b0);
    chk1("ed_c5_busy", b2.busy, 1'b0);
    b2.d_we = 0;

    // Contention from reset release: I, D, I, D
    rst_n = 1'b0;
    b2.i_req = 1; b2.i_addr = 32'h0040_0000;
    b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h1000_0000;
    nxt();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      nxt();
      chk1("ct_cs", b2.sram_cs, (k % 4 == 1) || (k % 4 == 2));
      chk1("ct_iack", b2.i_ack, (k == 3) || (k == 11));
      chk1("ct_dack", b2.d_ack, (k == 7) || (k == 15));
      if (k == 3) chk("ct_i_rdata", b2.i_rdata, 32'h8C01_0004);
      if (k == 5) chk("ct_d_addr", b2.sram_addr, 32'h1000_0000);
      if (k == 7) chk("ct_d_rdata", b2.d_rdata, 32'hDEAD_BEEF);
      if (k == 9) chk("ct_i_addr", b2.sram_addr, 32'h0040_0000);
      if (k == 15) begin
        b2.i_req = 0;
        b2.d_req = 0;
      end
    end
    nxt();
    chk1("ct_idle_cs", b2.sram_cs, 1'b0);

    // Reset mid-ACCESS: immediate clear, no ack, normal service afterwards
    b2.i_req = 1; b2.i_addr = 32'h1000_0000;
    nxt();
    nxt();
    rst_n = 1'b0;
    b2.i_req = 0;
    #1;
    chk1("mr_cs", b2.sram_cs, 1'b0);
    chk1("mr_oe", b2.sram_oe, 1'b0);
    chk1("mr_busy", b2.busy, 1'b0);
    chk("mr_addr", b2.sram_addr, 32'h0);
    chk("mr_i_rdata", b2.i_rdata, 32'h0);
    nxt();
    chk1("mr_c3_ack", b2.i_ack, 1'b0);
    rst_n = 1'b1;
    b2.i_req = 1;
    nxt(); nxt(); nxt();
    chk1("mr_post_ack", b2.i_ack, 1'b1);
    chk("mr_post_rdata", b2.i_rdata, 32'hDEAD_BEEF);
    b2.i_req = 0;
    nxt();

    // ACCESS_CYCLES=1 instance
    b1.i_req = 1; b1.i_addr = 32'h0040_0000;
    nxt();
    chk1("a1_c1_cs", b1.sram_cs, 1'b1);
    chk1("a1_c1_ack", b1.i_ack, 1'b0);
    nxt();
    chk1("a1_c2_cs", b1.sram_cs, 1'b0);
    chk1("a1_c2_ack", b1.i_ack, 1'b1);
    chk("a1_c2_rdata", b1.i_rdata, 32'h8C01_0004);
    b1.i_req = 0;
    nxt();
    chk1("a1_c3_ack", b1.i_ack, 1'b0);
    chk1("a1_c3_busy", b1.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one asynchronous sram instance between two requesters: the instruction-fetch port (read-only) and the data-memory port (read/write).
- Arbitrates between the two ports round-robin.
- Sequences sram_cs, sram_oe and sram_we through a fixed access window, then registers the read data and returns a one-cycle ack.
- Sits between the processor's fetch/mem stages and the sram model. This makes the sram usable as a unified memory in a multi-cycle or stalled datapath.

Parameters:
- ACCESS_CYCLES, default 2: cycles sram_cs stays high before sram_dout is sampled; must be >= 1 (elaboration error otherwise).
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request; level, hold until i_ack
- i_addr  in  ADDR_W  instruction address; stable while i_req high
- i_rdata  out  DATA_W  registered instruction read data
- i_ack  out  1  one-cycle completion pulse, instruction port
- d_req  in  1  data request; level, hold until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  registered data read data
- d_ack  out  1  one-cycle completion pulse, data port
- sram_cs  out  1  sram chip select
- sram_oe  out  1  sram output enable
- sram_we  out  1  sram write enable
- sram_addr  out  ADDR_W  sram address
- sram_din  out  DATA_W  sram write data
- sram_dout  in  DATA_W  sram read data
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=D so the instruction port wins first.
  - All outputs 0, including i_rdata and d_rdata.
  - An in-flight transaction is dropped with no ack.
- FSM states IDLE, ACCESS, RESP. All sram_* outputs are registered.
- IDLE:
  - Only one req high: grant that port.
  - Both high: grant the port != last_grant.
  - On grant:
    - Latch addr, we and wdata (instruction port forces we=0).
    - Drive sram_cs=1, sram_oe=!we, sram_we=we, sram_addr, sram_din (0 for reads).
    - Load cnt=ACCESS_CYCLES-1; go to ACCESS.
  - No req: stay in IDLE, sram_cs/oe/we=0.
- ACCESS:
  - cs, oe, we, addr and din held constant, so there are no glitches on the sram sensitivity list.
  - cnt>0: decrement.
  - cnt==0, read: capture sram_dout into the granted port's rdata register.
  - cnt==0 (read or write): go to RESP.
- RESP:
  - sram_cs, sram_oe and sram_we drop to 0; sram_addr and sram_din hold their last values.
  - Ack of the granted port = 1 for exactly this cycle.
  - last_grant <= granted port; go to IDLE.
- Latency: req seen in IDLE at cycle 0, cs high cycles 1..ACCESS_CYCLES, ack at cycle ACCESS_CYCLES+1.
- Throughput: back-to-back throughput is one transaction per ACCESS_CYCLES+2 cycles. The mandatory IDLE cycle deasserts cs between accesses.
- rdata registers:
  - Change only on completion of a read for that port.
  - A write leaves d_rdata unchanged.
  - i_rdata is never affected by data-port traffic.
- Protocol rules:
  - A req deasserted before its ack does not abort the transaction; the ack is still issued.
  - A req held high through its ack is treated as a new request in the following IDLE, subject to arbitration.
  - Payload changes while req is high are ignored after latching.
- Simultaneous events: new requests arriving during ACCESS/RESP are only evaluated in IDLE, with no queueing beyond the req level.

Decomposition:
- Package sram_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - Port-id constants PORT_I=0, PORT_D=1.
  - Width of cnt derived from ACCESS_CYCLES.
- Sub-module rr_arb2: two-request round-robin arbiter.
  - Combinational grant from req[1:0] and last_grant.
  - last_grant register updated on an update strobe asserted in RESP.
  - Uses the same clk/rst_n.

Test Plan:
- Reset mid-ACCESS (ACCESS_CYCLES=2): pull rst_n low at cycle 2 -> all outputs 0 immediately, no ack; first request after release is served normally.
- Instruction read: sram preloaded 0x00400000 -> 0x8C010004; i_req at cycle 0 -> sram_cs=sram_oe=1 in cycles 1-2 with sram_we=0, i_ack at cycle 3, i_rdata=0x8C010004.
- Data write then read: d_we=1, addr 0x10000000, wdata 0xDEADBEEF -> sram_we=1 and sram_oe=0 in cycles 1-2, d_ack at cycle 3, d_rdata unchanged (0). Then a read of the same address -> d_rdata=0xDEADBEEF, i_rdata unchanged.
- Contention: i_req and d_req both held high from reset release -> grant order I, D, I, D with acks at cycles 3, 7, 11, 15; sram_cs low in cycles 4, 8, 12.
- Early req drop: d_req pulsed one cycle -> full access still performed and d_ack issued at cycle 3; no second access starts.
- ACCESS_CYCLES=1 build: i_req at cycle 0 -> sram_cs high in cycle 1 only, i_ack at cycle 2, data captured correctly.
